// File: rtl/machine_ram_arbiter.sv
// Owner of the Machine datapath block RAM: round-robin valid/ready sharing
// between the core (port 0) and loader/debug (port 1), plus a full-RAM clear sweep.
module machine_ram_arbiter #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              system1000,
    input  logic              system1000_rstn,
    input  logic              clr_start,
    output logic              busy,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    state_t              state_r;
    logic [ADDR_W-1:0]   clr_ptr_r;
    logic                last_grant_r;
    logic                busy_r;
    logic                rsp0_valid_r;
    logic                rsp1_valid_r;

    logic                run_s;
    logic                clear_s;
    logic                grant0_s;
    logic                grant1_s;
    logic                ram_we_s;
    logic [ADDR_W-1:0]   ram_waddr_s;
    logic [DATA_W-1:0]   ram_wdata_s;
    logic [ADDR_W-1:0]   ram_raddr_s;

    // While reset is held the RAM is left untouched, so a sweep cut short keeps its partial result.
    assign run_s   = system1000_rstn && (state_r == ST_RUN);
    assign clear_s = system1000_rstn && (state_r == ST_CLEAR);

    // Round-robin grant: a lone requester always wins, contention goes to the port not served last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (run_s) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (req0_valid) begin
                grant0_s = 1'b1;
            end else if (req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // RAM port mux: clear sweep, then the granted requester, otherwise all-zero idle.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = '0;
        ram_wdata_s = '0;
        ram_raddr_s = '0;
        if (clear_s) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = clr_ptr_r;
            ram_wdata_s = CLEAR_VAL;
        end else if (grant0_s) begin
            if (req0_we) begin
                ram_we_s    = 1'b1;
                ram_waddr_s = req0_addr;
                ram_wdata_s = req0_wdata;
            end else begin
                ram_raddr_s = req0_addr;
            end
        end else if (grant1_s) begin
            if (req1_we) begin
                ram_we_s    = 1'b1;
                ram_waddr_s = req1_addr;
                ram_wdata_s = req1_wdata;
            end else begin
                ram_raddr_s = req1_addr;
            end
        end else begin
            ram_we_s    = 1'b0;
            ram_waddr_s = '0;
            ram_wdata_s = '0;
            ram_raddr_s = '0;
        end
    end

    // Sweep FSM, round-robin history and read-response tracking.
    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            state_r      <= ST_RUN;
            clr_ptr_r    <= '0;
            last_grant_r <= 1'b1;
            busy_r       <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (clr_start) begin
                        state_r <= ST_CLEAR;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    clr_ptr_r <= clr_ptr_r + PTR_ONE;
                    if (clr_ptr_r == PTR_LAST) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_CLEAR;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_RUN;
                    clr_ptr_r <= '0;
                    busy_r    <= 1'b0;
                end
            endcase
            if (grant0_s) begin
                last_grant_r <= 1'b0;
            end else if (grant1_s) begin
                last_grant_r <= 1'b1;
            end else begin
                last_grant_r <= last_grant_r;
            end
            rsp0_valid_r <= grant0_s && !req0_we;
            rsp1_valid_r <= grant1_s && !req1_we;
        end
    end

    assign busy       = busy_r;
    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    // The RAM output register already supplies the one-cycle read latency.
    assign rsp0_data  = ram_rdata;
    assign rsp1_data  = ram_rdata;
    assign ram_we     = ram_we_s;
    assign ram_waddr  = ram_waddr_s;
    assign ram_wdata  = ram_wdata_s;
    assign ram_raddr  = ram_raddr_s;

endmodule

// File: tb/tb_machine_ram_arbiter.sv
// Directed bench for machine_ram_arbiter with a behavioural 256x8 registered-read RAM.
module tb_machine_ram_arbiter;

    logic       system1000 = 1'b0;
    logic       system1000_rstn;
    logic       clr_start;
    logic       busy;
    logic       req0_valid, req0_ready, req0_we, rsp0_valid;
    logic [7:0] req0_addr, req0_wdata, rsp0_data;
    logic       req1_valid, req1_ready, req1_we, rsp1_valid;
    logic [7:0] req1_addr, req1_wdata, rsp1_data;
    logic       ram_we;
    logic [7:0] ram_waddr, ram_wdata, ram_raddr, ram_rdata;

    logic [7:0] mem [0:255];
    int total = 0;
    int bad   = 0;

    machine_ram_arbiter dut (
        .system1000(system1000), .system1000_rstn(system1000_rstn),
        .clr_start(clr_start), .busy(busy),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    always #5 system1000 = ~system1000;

    // Block RAM model: synchronous write, registered read.
    always @(posedge system1000) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    typedef struct {
        logic v0, we0; logic [7:0] a0, d0;
        logic v1, we1; logic [7:0] a1, d1;
        logic rdy0, rdy1, rwe; logic [7:0] wa, wd, ra;
        logic rv0, rv1; logic [7:0] rdat;
    } vec_t;
    vec_t vt [16];

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge system1000);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 8'h00; req0_wdata = 8'h00;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 8'h00; req1_wdata = 8'h00;
        clr_start  = 1'b0;
    endtask

    task automatic wr0(input logic [7:0] a, input logic [7:0] d);
        idle();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = a; req0_wdata = d;
        @(negedge system1000);
        chk1("wr0_ready", req0_ready, 1'b1);
        tick();
        idle();
    endtask

    task automatic rd0(input logic [7:0] a, input logic [7:0] exp);
        idle();
        req0_valid = 1'b1; req0_addr = a;
        @(negedge system1000);
        chk1("rd0_ready", req0_ready, 1'b1);
        chk8("rd0_raddr", ram_raddr, a);
        tick();
        idle();
        @(negedge system1000);
        chk1("rd0_rsp_valid", rsp0_valid, 1'b1);
        chk8("rd0_rsp_data", rsp0_data, exp);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        vt[0]  = '{1'b1,1'b1,8'h3C,8'hA5, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b1, 8'h3C,8'hA5,8'h00, 1'b0,1'b0,8'h00};
        vt[1]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h3C,8'h00, 1'b0,1'b1,1'b0, 8'h00,8'h00,8'h3C, 1'b0,1'b0,8'h00};
        vt[2]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00, 1'b0,1'b1,8'hA5};
        vt[3]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h01,8'h11, 1'b0,1'b1,1'b1, 8'h01,8'h11,8'h00, 1'b0,1'b0,8'h00};
        vt[4]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h02,8'h22, 1'b0,1'b1,1'b1, 8'h02,8'h22,8'h00, 1'b0,1'b0,8'h00};
        vt[5]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h03,8'h33, 1'b0,1'b1,1'b1, 8'h03,8'h33,8'h00, 1'b0,1'b0,8'h00};
        vt[6]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h01,8'h00, 1'b0,1'b1,1'b0, 8'h00,8'h00,8'h01, 1'b0,1'b0,8'h00};
        vt[7]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h02,8'h00, 1'b0,1'b1,1'b0, 8'h00,8'h00,8'h02, 1'b0,1'b1,8'h11};
        vt[8]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h03,8'h00, 1'b0,1'b1,1'b0, 8'h00,8'h00,8'h03, 1'b0,1'b1,8'h22};
        vt[9]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00, 1'b0,1'b1,8'h33};
        vt[10] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00, 1'b0,1'b0,8'h00};
        vt[11] = '{1'b1,1'b0,8'h3C,8'h00, 1'b1,1'b1,8'h50,8'h99, 1'b1,1'b0,1'b0, 8'h00,8'h00,8'h3C, 1'b0,1'b0,8'h00};
        vt[12] = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h50,8'h99, 1'b0,1'b1,1'b1, 8'h50,8'h99,8'h00, 1'b1,1'b0,8'hA5};
        vt[13] = '{1'b1,1'b0,8'h50,8'h00, 1'b1,1'b0,8'h01,8'h00, 1'b1,1'b0,1'b0, 8'h00,8'h00,8'h50, 1'b0,1'b0,8'h00};
        vt[14] = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h01,8'h00, 1'b0,1'b1,1'b0, 8'h00,8'h00,8'h01, 1'b1,1'b0,8'h99};
        vt[15] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00, 1'b0,1'b1,8'h11};

        // Reset for two cycles, then check the idle reset state.
        idle();
        system1000_rstn = 1'b0;
        tick();
        tick();
        system1000_rstn = 1'b1;
        @(negedge system1000);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
        chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
        chk1("rst_ram_we", ram_we, 1'b0);
        chk8("rst_raddr", ram_raddr, 8'h00);
        tick();

        // Full sweep; port 0 waits through it and a second clr_start mid-sweep is ignored.
        clr_start = 1'b1;
        @(negedge system1000);
        chk1("clr_start_busy", busy, 1'b0);
        chk1("clr_start_we", ram_we, 1'b0);
        tick();
        clr_start = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'hFF;
        for (int i = 0; i < 256; i++) begin
            clr_start = (i == 100);
            @(negedge system1000);
            chk1("sweep_busy", busy, 1'b1);
            chk1("sweep_we", ram_we, 1'b1);
            chk8("sweep_waddr", ram_waddr, 8'(i));
            chk8("sweep_wdata", ram_wdata, 8'h00);
            chk1("sweep_ready0", req0_ready, 1'b0);
            tick();
        end
        clr_start = 1'b0;
        @(negedge system1000);
        chk1("post_sweep_busy", busy, 1'b0);
        chk1("post_sweep_ready0", req0_ready, 1'b1);
        chk8("post_sweep_raddr", ram_raddr, 8'hFF);
        chk1("post_sweep_we", ram_we, 1'b0);
        tick();
        idle();
        @(negedge system1000);
        chk1("post_sweep_rsp0_valid", rsp0_valid, 1'b1);
        chk8("post_sweep_rsp0_data", rsp0_data, 8'h00);
        chk1("post_sweep_rsp1_valid", rsp1_valid, 1'b0);
        tick();

        // Table-driven handshake vectors.
        for (int i = 0; i < 16; i++) begin
            req0_valid = vt[i].v0; req0_we = vt[i].we0; req0_addr = vt[i].a0; req0_wdata = vt[i].d0;
            req1_valid = vt[i].v1; req1_we = vt[i].we1; req1_addr = vt[i].a1; req1_wdata = vt[i].d1;
            @(negedge system1000);
            chk1("vec_ready0", req0_ready, vt[i].rdy0);
            chk1("vec_ready1", req1_ready, vt[i].rdy1);
            chk1("vec_ram_we", ram_we, vt[i].rwe);
            chk8("vec_waddr", ram_waddr, vt[i].wa);
            chk8("vec_wdata", ram_wdata, vt[i].wd);
            chk8("vec_raddr", ram_raddr, vt[i].ra);
            chk1("vec_rsp0_valid", rsp0_valid, vt[i].rv0);
            chk1("vec_rsp1_valid", rsp1_valid, vt[i].rv1);
            if (vt[i].rv0) chk8("vec_rsp0_data", rsp0_data, vt[i].rdat);
            if (vt[i].rv1) chk8("vec_rsp1_data", rsp1_data, vt[i].rdat);
            tick();
        end
        idle();

        // Both ports read continuously from reset: strict alternation starting with port 0.
        system1000_rstn = 1'b0;
        req0_valid = 1'b1; req0_addr = 8'h3C;
        req1_valid = 1'b1; req1_addr = 8'h01;
        tick();
        system1000_rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge system1000);
            chk1("rr_ready0", req0_ready, (k % 2) == 0);
            chk1("rr_ready1", req1_ready, (k % 2) == 1);
            chk8("rr_raddr", ram_raddr, ((k % 2) == 0) ? 8'h3C : 8'h01);
            chk1("rr_rsp0_valid", rsp0_valid, (k % 2) == 1);
            chk1("rr_rsp1_valid", rsp1_valid, ((k % 2) == 0) && (k > 0));
            if ((k % 2) == 1) chk8("rr_rsp0_data", rsp0_data, 8'hA5);
            if (((k % 2) == 0) && (k > 0)) chk8("rr_rsp1_data", rsp1_data, 8'h11);
            tick();
        end
        // Reset while reads are in flight drops the pending responses.
        system1000_rstn = 1'b0;
        tick();
        system1000_rstn = 1'b1;
        idle();
        @(negedge system1000);
        chk1("rst_read_rsp0", rsp0_valid, 1'b0);
        chk1("rst_read_rsp1", rsp1_valid, 1'b0);
        tick();

        // Reset in the middle of a sweep leaves the upper half untouched.
        wr0(8'h80, 8'h5A);
        wr0(8'hFF, 8'hC3);
        wr0(8'h7F, 8'h77);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 128; i++) tick();
        system1000_rstn = 1'b0;
        @(negedge system1000);
        chk1("midclr_rst_we", ram_we, 1'b0);
        tick();
        system1000_rstn = 1'b1;
        @(negedge system1000);
        chk1("midclr_busy", busy, 1'b0);
        chk1("midclr_we", ram_we, 1'b0);
        chk8("midclr_mem7f", mem[8'h7F], 8'h00);
        chk8("midclr_mem80", mem[8'h80], 8'h5A);
        chk8("midclr_memff", mem[8'hFF], 8'hC3);
        tick();
        rd0(8'h80, 8'h5A);
        rd0(8'h7F, 8'h00);
        // A fresh sweep restarts at address zero.
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        @(negedge system1000);
        chk1("restart_busy", busy, 1'b1);
        chk1("restart_we", ram_we, 1'b1);
        chk8("restart_waddr", ram_waddr, 8'h00);
        for (int i = 0; i < 256; i++) tick();
        @(negedge system1000);
        chk1("restart_done_busy", busy, 1'b0);
        chk8("restart_mem80", mem[8'h80], 8'h00);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
